pulse_period_monitor: RTL and testbench
=======================================

Name: pulse_period_monitor

Overview:
Receive-side checker for the one-cycle periodic tick that drives the Gray counter timebase. It measures the pulse-to-pulse interval in clock cycles and reports each measured period. It flags early or late ticks and asserts a lock indication after consecutive in-tolerance periods. It sits between the tick generator and the counter logic, and its outputs also drive debug LEDs.

Parameters:
CNT_W, 28, width of the interval counter and of period_out
DISTANCE, 100000000, generator distance; nominal interval is NOM = DISTANCE+1 cycles
TOL, 1000, accepted deviation in cycles; window is [NOM-TOL, NOM+TOL], inclusive
LOCK_CNT, 3, number of consecutive in-window periods required to assert locked

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
pulse_in  in  1  one-cycle tick from the generator
clr_err  in  1  synchronous clear for err_sticky
period_out  out  CNT_W  last measured interval in cycles
period_valid  out  1  one-cycle strobe; period_out is updated on this strobe
locked  out  1  high while LOCK_CNT or more consecutive good periods have been seen
err_early  out  1  one-cycle strobe: interval < NOM-TOL
err_late  out  1  one-cycle strobe: interval > NOM+TOL, or timeout
err_sticky  out  1  set by either error, held until clr_err

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0, elapsed goes to 0, good_cnt goes to 0, state goes to IDLE.
- All outputs are registered. Every response appears the cycle after the causing pulse_in or timeout cycle.
- elapsed counter:
  - On a pulse_in cycle, elapsed is set to 0.
  - Otherwise elapsed increments, saturating at 2^CNT_W-1.
  - Measured period P = elapsed+1 on the pulse cycle, which equals t1-t0.
- States:
  - IDLE: waiting for a reference pulse. pulse_in goes to MEASURE with no period_valid.
  - MEASURE: pulse_in produces period_valid with period_out=P, then classification:
    - P in window: good_cnt+1. When it reaches LOCK_CNT, go to LOCKED and set locked=1.
    - P < NOM-TOL: err_early, good_cnt=0, stay in MEASURE.
  - LOCKED: an in-window pulse reports the period and stays in LOCKED (good_cnt saturates). An early pulse reports the period, raises err_early, clears locked, sets good_cnt=0 and goes to MEASURE.
- Timeout (MEASURE or LOCKED), when elapsed == NOM+TOL:
  - Without pulse_in: err_late, locked=0, good_cnt=0, go to IDLE, no period_valid.
  - With pulse_in on the same cycle: period_valid with P = NOM+TOL+1, plus err_late, locked=0, good_cnt=0, go to MEASURE. The new pulse becomes the reference.
- Pulses in IDLE never produce an error.
- err_sticky: set on any err_early or err_late. If set and clr_err occur in the same cycle, set wins.
- Legal parameters: TOL < NOM, NOM+TOL+1 < 2^CNT_W, LOCK_CNT >= 1. The counter never wraps in MEASURE or LOCKED.
- Reset mid-operation: everything is discarded. The first pulse after reset is only a reference.

Decomposition:
- Shared package gray_timing_pkg holds:
  - state encoding (IDLE=0, MEASURE=1, LOCKED=2)
  - default DISTANCE and CNT_W, shared with the tick generator so the two ends agree
- No sub-module. This is one module: elapsed counter, window compare, good_cnt, FSM and output registers.

Test Plan:
All scenarios use CNT_W=8, DISTANCE=9 (NOM=10), TOL=2, LOCK_CNT=3.
1. Reset: hold rst=0 for 3 cycles, pulse_in toggling -> all outputs 0. Release, one pulse -> no period_valid, no error.
2. Four pulses spaced 10 cycles -> three period_valid strobes with period_out=10. locked=1 the cycle after the 4th pulse. No errors.
3. Locked, next pulse after 7 cycles -> period_out=7, err_early=1 for one cycle, locked=0, err_sticky=1. Three more 10-cycle periods -> locked=1 again.
4. Locked, no further pulse -> err_late=1 the cycle after elapsed==12, locked=0. The next pulse gives no period_valid. Two later 10-cycle pulses -> period_valid=10 with no error.
5. Window edges: periods 8 and 12 are accepted with no error. Period 13 (pulse on the timeout cycle) -> period_valid with 13, plus err_late, state MEASURE.
6. err_sticky=1, then clr_err pulse -> 0. Error strobe and clr_err in the same cycle -> err_sticky stays 1. Drive rst=0 mid-LOCKED -> locked drops without waiting for a clock edge.

Source files
------------

// File: rtl/gray_timing_pkg.sv
// Timing constants and monitor state encoding shared by the Gray-counter tick
// generator and the receive-side period monitor.
package gray_timing_pkg;

   localparam int unsigned DEFAULT_DISTANCE = 100000000;
   localparam int unsigned DEFAULT_CNT_W    = 28;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StMeasure = 2'd1,
      StLocked  = 2'd2
   } mon_state_e;

endpackage

// File: rtl/pulse_period_monitor.sv
// Measures the interval between one-cycle ticks, classifies it against a tolerance
// window around the nominal period and reports lock after consecutive good periods.
module pulse_period_monitor
   import gray_timing_pkg::*;
#(
   parameter int unsigned CNT_W    = DEFAULT_CNT_W,
   parameter int unsigned DISTANCE = DEFAULT_DISTANCE,
   parameter int unsigned TOL      = 1000,
   parameter int unsigned LOCK_CNT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pulse_in,
   input  logic             clr_err,
   output logic [CNT_W-1:0] period_out,
   output logic             period_valid,
   output logic             locked,
   output logic             err_early,
   output logic             err_late,
   output logic             err_sticky
);

   localparam int unsigned      NOM       = DISTANCE + 1;
   localparam logic [CNT_W-1:0] TMO_VAL   = CNT_W'(NOM + TOL);
   localparam logic [CNT_W-1:0] EARLY_LIM = CNT_W'(NOM - TOL);
   localparam int unsigned      GW        = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
   localparam logic [GW-1:0]    LOCK_VAL  = GW'(LOCK_CNT);

   mon_state_e       state_q, state_d;
   logic [CNT_W-1:0] elapsed_q, elapsed_d;
   logic [GW-1:0]    good_q, good_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             valid_q, valid_d;
   logic             locked_q, locked_d;
   logic             early_q, early_d;
   logic             late_q, late_d;
   logic             sticky_q, sticky_d;

   logic [CNT_W-1:0] meas;
   logic             timeout;
   logic             too_early;

   assign meas      = elapsed_q + CNT_W'(1);
   assign timeout   = (state_q != StIdle) && (elapsed_q == TMO_VAL);
   assign too_early = meas < EARLY_LIM;

   always_comb begin
      elapsed_d = elapsed_q;
      state_d   = state_q;
      good_d    = good_q;
      period_d  = period_q;
      valid_d   = 1'b0;
      early_d   = 1'b0;
      late_d    = 1'b0;

      if (pulse_in) begin
         elapsed_d = '0;
      end else if (elapsed_q != '1) begin
         elapsed_d = elapsed_q + CNT_W'(1);
      end

      unique case (state_q)
         StIdle: begin
            if (pulse_in) begin
               state_d = StMeasure;
               good_d  = '0;
            end
         end
         StMeasure, StLocked: begin
            if (timeout) begin
               // A pulse exactly on the timeout cycle is reported and becomes the new reference.
               late_d  = 1'b1;
               good_d  = '0;
               state_d = pulse_in ? StMeasure : StIdle;
               if (pulse_in) begin
                  valid_d  = 1'b1;
                  period_d = meas;
               end
            end else if (pulse_in) begin
               valid_d  = 1'b1;
               period_d = meas;
               if (too_early) begin
                  early_d = 1'b1;
                  good_d  = '0;
                  state_d = StMeasure;
               end else begin
                  if (good_q != LOCK_VAL) begin
                     good_d = good_q + GW'(1);
                  end
                  if (good_d == LOCK_VAL) begin
                     state_d = StLocked;
                  end
               end
            end
         end
         default: begin
            state_d = StIdle;
            good_d  = '0;
         end
      endcase

      locked_d = (state_d == StLocked);

      if (early_d || late_d) begin
         sticky_d = 1'b1;
      end else if (clr_err) begin
         sticky_d = 1'b0;
      end else begin
         sticky_d = sticky_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         elapsed_q <= '0;
         good_q    <= '0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         early_q   <= 1'b0;
         late_q    <= 1'b0;
         sticky_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         elapsed_q <= elapsed_d;
         good_q    <= good_d;
         period_q  <= period_d;
         valid_q   <= valid_d;
         locked_q  <= locked_d;
         early_q   <= early_d;
         late_q    <= late_d;
         sticky_q  <= sticky_d;
      end
   end

   assign period_out   = period_q;
   assign period_valid = valid_q;
   assign locked       = locked_q;
   assign err_early    = early_q;
   assign err_late     = late_q;
   assign err_sticky   = sticky_q;

endmodule

// File: tb/tb_pulse_period_monitor.sv
// Bench for pulse_period_monitor: scenario tasks plus random pulse trains checked
// against a timestamp-based reference model.
module tb_pulse_period_monitor;

   localparam int unsigned CNT_W    = 8;
   localparam int unsigned DISTANCE = 9;
   localparam int unsigned TOL      = 2;
   localparam int unsigned LOCK_CNT = 3;
   localparam int          NOM      = DISTANCE + 1;

   logic             clk      = 1'b0;
   logic             rst      = 1'b0;
   logic             pulse_in = 1'b0;
   logic             clr_err  = 1'b0;
   logic [CNT_W-1:0] period_out;
   logic             period_valid;
   logic             locked;
   logic             err_early;
   logic             err_late;
   logic             err_sticky;

   pulse_period_monitor #(
      .CNT_W    (CNT_W),
      .DISTANCE (DISTANCE),
      .TOL      (TOL),
      .LOCK_CNT (LOCK_CNT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pulse_in     (pulse_in),
      .clr_err      (clr_err),
      .period_out   (period_out),
      .period_valid (period_valid),
      .locked       (locked),
      .err_early    (err_early),
      .err_late     (err_late),
      .err_sticky   (err_sticky)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model: timestamps of the reference pulse, not an elapsed counter.
   bit         have_ref;
   int         ref_t;
   int         good;
   logic [7:0] m_period;
   bit         m_valid, m_locked, m_early, m_late, m_sticky;

   function automatic void model_clear();
      have_ref = 0; ref_t = 0; good = 0; m_period = '0;
      m_valid = 0; m_locked = 0; m_early = 0; m_late = 0; m_sticky = 0;
   endfunction

   function automatic void model_step(input bit p, input bit c);
      int d;
      m_valid = 0; m_early = 0; m_late = 0;
      if (have_ref) begin
         d = cyc - ref_t;
         if (d == NOM + TOL + 1) begin
            m_late = 1; good = 0; m_locked = 0;
            if (p) begin m_valid = 1; m_period = 8'(d); ref_t = cyc; end
            else have_ref = 0;
         end else if (p) begin
            m_valid = 1; m_period = 8'(d); ref_t = cyc;
            if (d < NOM - TOL) begin
               m_early = 1; good = 0; m_locked = 0;
            end else begin
               good++;
               if (good >= LOCK_CNT) m_locked = 1;
            end
         end
      end else if (p) begin
         have_ref = 1; ref_t = cyc;
      end
      if (m_early || m_late) m_sticky = 1;
      else if (c) m_sticky = 0;
   endfunction

   function automatic logic [12:0] obs_vec();
      return {period_out, period_valid, locked, err_early, err_late, err_sticky};
   endfunction

   function automatic logic [12:0] exp_vec();
      return {m_period, m_valid, m_locked, m_early, m_late, m_sticky};
   endfunction

   task automatic step(input bit p, input bit c);
      @(negedge clk);
      pulse_in = p;
      clr_err  = c;
      @(posedge clk);
      model_step(p, c);
      cyc++;
      #1;
   endtask

   // Idle for n-1 cycles, then pulse (optionally with clr_err on the pulse cycle).
   task automatic gap(input int n, input bit clr_last);
      for (int c = 1; c <= n; c++) step(c == n, clr_last && (c == n));
   endtask

   task automatic reset_quiet();
      @(negedge clk);
      rst = 1'b0; pulse_in = 1'b0; clr_err = 1'b0;
      model_clear();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      model_clear();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         pulse_in = ~pulse_in;
         @(posedge clk);
         #1;
         total++;
         if (obs_vec() !== 13'h0) begin
            bad++;
            $display("FAIL reset_hold cyc=%0d got=%h want=%h", cyc, obs_vec(), 13'h0);
         end
      end
      @(negedge clk);
      pulse_in = 1'b0;
      rst = 1'b1;
      step(1, 0);
      total++;
      if ({period_valid, err_early, err_late, err_sticky} !== 4'b0 || obs_vec() !== exp_vec()) begin
         bad++;
         $display("FAIL reset_first_pulse got=%h want=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_lock();
      reset_quiet();
      step(1, 0);
      for (int k = 0; k < 3; k++) begin
         gap(10, 0);
         total++;
         if (!period_valid || period_out !== 8'd10 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL lock_period k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
         end
      end
      total++;
      if (locked !== 1'b1 || err_sticky !== 1'b0) begin
         bad++;
         $display("FAIL lock_asserted got locked=%b sticky=%b want locked=1 sticky=0",
                  locked, err_sticky);
      end
   endtask

   task automatic test_early();
      gap(7, 0);
      total++;
      if ({period_valid, period_out, err_early, locked, err_sticky} !== {1'b1, 8'd7, 3'b101}
          || obs_vec() !== exp_vec()) begin
         bad++;
         $display("FAIL early_pulse got=%h want=%h", obs_vec(), exp_vec());
      end
      for (int k = 0; k < 3; k++) begin
         gap(10, 0);
         total++;
         if (err_early !== 1'b0 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL early_relock k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
         end
      end
      total++;
      if (locked !== 1'b1) begin
         bad++;
         $display("FAIL early_relocked got=%b want=1", locked);
      end
   endtask

   task automatic test_timeout();
      for (int c = 1; c <= 13; c++) begin
         step(0, 0);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL timeout_wait c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
         end
      end
      total++;
      if ({err_late, locked, period_valid} !== 3'b100) begin
         bad++;
         $display("FAIL timeout_late got late/locked/valid=%b want=100",
                  {err_late, locked, period_valid});
      end
      step(0, 0);
      step(0, 0);
      step(1, 0);
      total++;
      if ({period_valid, err_early, err_late} !== 3'b000) begin
         bad++;
         $display("FAIL timeout_idle_pulse got=%b want=000", {period_valid, err_early, err_late});
      end
      for (int k = 0; k < 2; k++) begin
         gap(10, 0);
         total++;
         if ({period_valid, period_out, err_early, err_late} !== {1'b1, 8'd10, 2'b00}) begin
            bad++;
            $display("FAIL timeout_remeasure k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_window();
      int          gaps[4] = '{8, 12, 13, 10};
      logic [10:0] want[4] = '{{1'b1, 8'd8, 2'b00}, {1'b1, 8'd12, 2'b00},
                               {1'b1, 8'd13, 2'b01}, {1'b1, 8'd10, 2'b00}};
      reset_quiet();
      step(1, 0);
      for (int k = 0; k < 4; k++) begin
         gap(gaps[k], 0);
         total++;
         if ({period_valid, period_out, err_early, err_late} !== want[k]
             || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL window gap=%0d got=%h want=%h", gaps[k], obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_sticky();
      reset_quiet();
      step(1, 0);
      gap(7, 0);
      step(0, 1);
      total++;
      if (err_sticky !== 1'b0) begin
         bad++;
         $display("FAIL sticky_clear got=%b want=0", err_sticky);
      end
      gap(6, 1);
      total++;
      if ({err_early, err_sticky} !== 2'b11) begin
         bad++;
         $display("FAIL sticky_set_wins got=%b want=11", {err_early, err_sticky});
      end
      for (int k = 0; k < 3; k++) gap(10, 0);
      total++;
      if (locked !== 1'b1 || obs_vec() !== exp_vec()) begin
         bad++;
         $display("FAIL sticky_lock got=%h want=%h", obs_vec(), exp_vec());
      end
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      model_clear();
      total++;
      if (obs_vec() !== 13'h0) begin
         bad++;
         $display("FAIL async_reset got=%h want=%h", obs_vec(), 13'h0);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_random();
      int n;
      reset_quiet();
      for (int g = 0; g < 40; g++) begin
         n = $urandom_range(5, 15);
         for (int c = 1; c <= n; c++) begin
            step(c == n, $urandom_range(0, 7) == 0);
            total++;
            if (obs_vec() !== exp_vec()) begin
               bad++;
               $display("FAIL random g=%0d c=%0d got=%h want=%h", g, c, obs_vec(), exp_vec());
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_early();
      test_timeout();
      test_window();
      test_sticky();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
